// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU sequencer: walks a WIDTH-bit operation through an external
// 4-bit ALU slice, one nibble per cycle, chaining the carry for ADD/SUB.
module alu_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             err,
    output logic [3:0]       alu_d1,
    output logic [3:0]       alu_d2,
    output logic [4:0]       alu_ctrl,
    input  logic [3:0]       alu_res,
    input  logic             alu_carry
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] CMD_ADD = 5'b00000;
    localparam logic [4:0] CMD_SUB = 5'b11000;
    localparam logic [4:0] CMD_XOR = 5'b00100;
    localparam logic [4:0] CMD_AND = 5'b00101;
    localparam logic [4:0] CMD_OR  = 5'b00110;

    function automatic logic cmd_legal(input logic [4:0] c);
        case (c)
            CMD_ADD, CMD_SUB, CMD_XOR, CMD_AND, CMD_OR: cmd_legal = 1'b1;
            default:                                    cmd_legal = 1'b0;
        endcase
    endfunction

    function automatic logic cmd_arith(input logic [4:0] c);
        cmd_arith = (c == CMD_ADD) || (c == CMD_SUB);
    endfunction

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [4:0]       cmd_lat;
    logic             carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            cmd_lat   <= '0;
            carry_q   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_lat     <= a;
                        b_lat     <= b;
                        cmd_lat   <= cmd;
                        k         <= '0;
                        carry_q   <= 1'b0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        err       <= !cmd_legal(cmd);
                        state     <= cmd_legal(cmd) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    result[{k, 2'b00} +: 4] <= alu_res;
                    carry_q                 <= alu_carry;
                    if (k == K_LAST) begin
                        // Logical ops never report a carry, whatever the slice says.
                        carry_out <= cmd_arith(cmd_lat) ? alu_carry : 1'b0;
                        state     <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        alu_d1   = '0;
        alu_d2   = '0;
        alu_ctrl = '0;
        if (state == S_RUN) begin
            alu_d1        = a_lat[{k, 2'b00} +: 4];
            alu_d2        = b_lat[{k, 2'b00} +: 4];
            alu_ctrl[3:0] = cmd_lat[3:0];
            // Nibble 0 takes the command's own carry-in (1 for SUB); later nibbles chain.
            if (k == '0)
                alu_ctrl[4] = cmd_lat[4];
            else if (cmd_arith(cmd_lat))
                alu_ctrl[4] = carry_q;
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with a behavioural 4-bit ALU slice attached.
module tb_alu_nibble_seq;

    localparam logic [4:0] ADD = 5'b00000;
    localparam logic [4:0] SUB = 5'b11000;
    localparam logic [4:0] XOR = 5'b00100;
    localparam logic [4:0] AND = 5'b00101;
    localparam logic [4:0] OR  = 5'b00110;
    localparam logic [4:0] BAD = 5'b01111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  cmd = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, carry_out, err;
    logic [15:0] result;
    logic [3:0]  alu_d1, alu_d2, alu_res;
    logic [4:0]  alu_ctrl;
    logic        alu_carry;

    int n_checks = 0;
    int n_pass   = 0;

    alu_nibble_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .err(err),
        .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    // 4-bit ALU slice: ctrl = {carry_in, b_inv, carry_disable, op[1:0]}
    logic [3:0] d2x;
    logic [4:0] sum;
    always_comb begin
        d2x       = alu_ctrl[3] ? ~alu_d2 : alu_d2;
        sum       = {1'b0, alu_d1} + {1'b0, d2x} + {4'b0, alu_ctrl[4]};
        alu_res   = 4'h0;
        alu_carry = 1'b0;
        case (alu_ctrl[1:0])
            2'b00: begin
                if (alu_ctrl[2]) alu_res = alu_d1 ^ d2x;
                else begin
                    alu_res   = sum[3:0];
                    alu_carry = sum[4];
                end
            end
            2'b01:   alu_res = alu_d1 & d2x;
            2'b10:   alu_res = alu_d1 | d2x;
            default: alu_res = 4'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issues one operation and follows it to done; poke pulses start during RUN and DONE.
    task automatic run_op(input string tag, input logic [4:0] c, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] exp_res,
                          input logic exp_c, input logic exp_e, input bit poke);
        int  edges;
        int  busy_cycles;
        bit  seen;
        edges = 0;
        busy_cycles = 0;
        seen = 0;
        @(negedge clk);
        cmd = c; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; cmd = 5'b11111;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                check({tag, "_d1_first"}, alu_d1, exp_e ? 4'h0 : av[3:0]);
                check({tag, "_d2_first"}, alu_d2, exp_e ? 4'h0 : bv[3:0]);
                check({tag, "_ctrl_first"}, alu_ctrl, exp_e ? 5'b0 : c);
            end
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                break;
            end
            start = poke && (i == 1);
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_done_edge"}, edges, exp_e ? 1 : 5);
        check({tag, "_busy_cycles"}, busy_cycles, exp_e ? 1 : 5);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_carry"}, carry_out, exp_c);
        check({tag, "_err"}, err, exp_e);
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_no_queue"}, busy, 0);
            check({tag, "_result_held"}, result, exp_res);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry_out, 0);
        check("rst_err", err, 0);
        check("rst_ctrl", {alu_ctrl, alu_d1, alu_d2}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add1", ADD, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 0);
        run_op("add_wrap", ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0);
        run_op("sub_b2b", SUB, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0, 0);
        run_op("sub_neg", SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op("sub_msb", SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 0);
        run_op("xor", XOR, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 0);
        run_op("and", AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 0);
        run_op("or", OR, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 0);
        run_op("illegal", BAD, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 0);
        run_op("ignore_start", ADD, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1);

        // Abort an ADD while nibble 2 is on the slice.
        @(negedge clk);
        cmd = ADD; a = 16'h1234; b = 16'h0FCD; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_d1_k2", alu_d1, 4'h2);
        check("abort_d2_k2", alu_d2, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_carry", carry_out, 0);
        check("abort_slice", {alu_ctrl, alu_d1, alu_d2}, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        run_op("post_rst", ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
